// File: rtl/framebuffer_scanout.sv
// Double-buffered 2bpp frame store fed by the pGB write port, streamed out as
// palette-mapped pixels in raster order over a valid/ready handshake.
module framebuffer_scanout #(
    parameter int WORDS_PER_ROW = 32,
    parameter int ROWS          = 256,
    parameter int ADDR_W        = $clog2(WORDS_PER_ROW * ROWS),
    parameter int LAST_ADDR     = WORDS_PER_ROW * ROWS - 1
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iFrameBufferWe,
    input  logic [15:0] iFrameBufferAddr,
    input  logic [15:0] iFrameBufferData,
    input  logic [7:0]  iBGP,
    output logic [1:0]  oPixel,
    output logic        oPixelValid,
    input  logic        iPixelReady,
    output logic        oLineStart,
    output logic        oFrameStart,
    output logic        oFrontBank,
    output logic        oSwapPending
);

    localparam int Y_W   = ADDR_W - 5;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL_RD = 2'd1,
        FILL_LD = 2'd2,
        STREAM  = 2'd3
    } state_t;

    function automatic logic [1:0] shade(input logic [7:0] bgp, input logic [1:0] p);
        logic [1:0] s;
        case (p)
            2'd0:    s = bgp[1:0];
            2'd1:    s = bgp[3:2];
            2'd2:    s = bgp[5:4];
            2'd3:    s = bgp[7:6];
            default: s = bgp[1:0];
        endcase
        return s;
    endfunction

    state_t              state_r, state_nxt_s;
    logic                front_r, pending_r;
    logic [7:0]          x_r;
    logic [Y_W-1:0]      y_r;
    logic [15:0]         sr_r, rd_data_r;
    logic [1:0]          pixel_r;
    logic                valid_r, line_start_r, frame_start_r;
    logic [15:0]         mem0 [0:DEPTH-1];
    logic [15:0]         mem1 [0:DEPTH-1];

    logic                accept_s, last_pix_s, completion_s;
    logic [7:0]          nx_s;
    logic [Y_W-1:0]      ny_s;
    logic                do_swap_s, rd_en_s, load_first_s, advance_s;
    logic [ADDR_W-1:0]   rd_addr_s;
    logic                unused_addr_s;

    assign unused_addr_s = ^iFrameBufferAddr[15:ADDR_W];

    assign accept_s     = valid_r & iPixelReady;
    assign last_pix_s   = (x_r == 8'd255) && (y_r == Y_W'(ROWS - 1));
    assign completion_s = iFrameBufferWe && (iFrameBufferAddr[ADDR_W-1:0] == ADDR_W'(LAST_ADDR));
    assign nx_s         = x_r + 8'd1;
    assign ny_s         = (x_r == 8'd255) ? (y_r + Y_W'(1)) : y_r;

    // FSM state register
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (pending_r) state_nxt_s = FILL_RD;
                else           state_nxt_s = IDLE;
            end
            FILL_RD: state_nxt_s = FILL_LD;
            FILL_LD: state_nxt_s = STREAM;
            STREAM: begin
                if (accept_s && last_pix_s) state_nxt_s = FILL_RD;
                else                        state_nxt_s = STREAM;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM control outputs: bank swap, RAM read requests and pixel advance
    always_comb begin
        do_swap_s    = 1'b0;
        rd_en_s      = 1'b0;
        rd_addr_s    = ADDR_W'(0);
        load_first_s = 1'b0;
        advance_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (pending_r) do_swap_s = 1'b1;
                else           do_swap_s = 1'b0;
            end
            FILL_RD: begin
                rd_en_s   = 1'b1;
                rd_addr_s = ADDR_W'(0);
            end
            FILL_LD: begin
                load_first_s = 1'b1;
                rd_en_s      = 1'b1;
                rd_addr_s    = ADDR_W'(1);
            end
            STREAM: begin
                if (accept_s) begin
                    advance_s = 1'b1;
                    if (last_pix_s) begin
                        do_swap_s = pending_r;
                    end else if (nx_s[2:0] == 3'd0) begin
                        // prefetch the word after the one being loaded now
                        rd_en_s   = 1'b1;
                        rd_addr_s = {ny_s, nx_s[7:3]} + ADDR_W'(1);
                    end else begin
                        rd_en_s = 1'b0;
                    end
                end else begin
                    advance_s = 1'b0;
                end
            end
            default: begin
                do_swap_s = 1'b0;
            end
        endcase
    end

    // Bank select and completed-frame flag
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            front_r   <= 1'b0;
            pending_r <= 1'b0;
        end else begin
            front_r   <= front_r ^ do_swap_s;
            pending_r <= completion_s | (pending_r & ~do_swap_s);
        end
    end

    // Write port: always into the back bank, never stalled
    always_ff @(posedge iClock) begin
        if (iFrameBufferWe) begin
            if (front_r) mem0[iFrameBufferAddr[ADDR_W-1:0]] <= iFrameBufferData;
            else         mem1[iFrameBufferAddr[ADDR_W-1:0]] <= iFrameBufferData;
        end
    end

    // Read port of the front bank; the output register doubles as prefetch buffer
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            rd_data_r <= 16'h0000;
        end else if (rd_en_s) begin
            rd_data_r <= front_r ? mem1[rd_addr_s] : mem0[rd_addr_s];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    // Pixel shifter, raster counters and registered outputs
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            x_r           <= 8'd0;
            y_r           <= Y_W'(0);
            sr_r          <= 16'h0000;
            pixel_r       <= 2'd0;
            valid_r       <= 1'b0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (load_first_s) begin
            x_r           <= 8'd0;
            y_r           <= Y_W'(0);
            sr_r          <= rd_data_r;
            pixel_r       <= shade(iBGP, rd_data_r[15:14]);
            valid_r       <= 1'b1;
            line_start_r  <= 1'b1;
            frame_start_r <= 1'b1;
        end else if (advance_s) begin
            x_r           <= nx_s;
            y_r           <= ny_s;
            frame_start_r <= 1'b0;
            line_start_r  <= (nx_s == 8'd0);
            if (last_pix_s) begin
                valid_r <= 1'b0;
            end else if (nx_s[2:0] == 3'd0) begin
                sr_r    <= rd_data_r;
                pixel_r <= shade(iBGP, rd_data_r[15:14]);
            end else begin
                sr_r    <= {sr_r[13:0], 2'b00};
                pixel_r <= shade(iBGP, sr_r[13:12]);
            end
        end else begin
            valid_r <= valid_r;
        end
    end

    assign oPixel       = pixel_r;
    assign oPixelValid  = valid_r;
    assign oLineStart   = line_start_r;
    assign oFrameStart  = frame_start_r;
    assign oFrontBank   = front_r;
    assign oSwapPending = pending_r;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Directed bench for framebuffer_scanout, built with an 8-row frame so that
// several whole frames fit in a short run.
module tb_framebuffer_scanout;

    localparam int FRAME_WORDS = 256;
    localparam int FRAME_PIX   = 2048;

    logic        iClock;
    logic        iReset;
    logic        iFrameBufferWe;
    logic [15:0] iFrameBufferAddr;
    logic [15:0] iFrameBufferData;
    logic [7:0]  iBGP;
    logic [1:0]  oPixel;
    logic        oPixelValid;
    logic        iPixelReady;
    logic        oLineStart;
    logic        oFrameStart;
    logic        oFrontBank;
    logic        oSwapPending;

    int n_cmp = 0;
    int n_bad = 0;

    framebuffer_scanout #(.ROWS(8)) dut (
        .iClock           (iClock),
        .iReset           (iReset),
        .iFrameBufferWe   (iFrameBufferWe),
        .iFrameBufferAddr (iFrameBufferAddr),
        .iFrameBufferData (iFrameBufferData),
        .iBGP             (iBGP),
        .oPixel           (oPixel),
        .oPixelValid      (oPixelValid),
        .iPixelReady      (iPixelReady),
        .oLineStart       (oLineStart),
        .oFrameStart      (oFrameStart),
        .oFrontBank       (oFrontBank),
        .oSwapPending     (oSwapPending)
    );

    always #5 iClock = ~iClock;

    task automatic write_word(input logic [15:0] addr, input logic [15:0] data);
        iFrameBufferWe   = 1'b1;
        iFrameBufferAddr = addr;
        iFrameBufferData = data;
        @(posedge iClock); #1;
        iFrameBufferWe   = 1'b0;
    endtask

    // Accepts pixels start_idx..stop_idx-1 of a frame whose words all equal word_val,
    // optionally writing the tail of the next frame into the back bank meanwhile.
    task automatic scan_frame(input string name, input logic [15:0] word_val, input logic [7:0] bgp_val,
                              input bit rand_ready, input int write_words, input logic [15:0] write_val,
                              input int start_idx, input int stop_idx);
        int acc = start_idx;
        int cyc = 0;
        int bad = 0;
        int bubbles = 0;
        int hold_bad = 0;
        int wi = 0;
        int first_i = -1;
        int x;
        bit started = (start_idx > 0);
        bit hold_prev = 1'b0;
        logic [1:0] p;
        logic [3:0] act, expv, prev_out, first_act, first_exp;
        prev_out  = 4'h0;
        first_act = 4'h0;
        first_exp = 4'h0;
        while (acc < stop_idx && cyc < 20000) begin
            iPixelReady = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (wi < write_words) begin
                iFrameBufferWe   = 1'b1;
                iFrameBufferAddr = 16'(FRAME_WORDS - write_words + wi);
                iFrameBufferData = write_val;
                wi++;
            end else begin
                iFrameBufferWe = 1'b0;
            end
            act = {oPixel, oLineStart, oFrameStart};
            if (hold_prev && act !== prev_out) hold_bad++;
            if (started && oPixelValid !== 1'b1) bubbles++;
            if (oPixelValid === 1'b1 && iPixelReady === 1'b1) begin
                x = acc % 256;
                p = 2'((word_val >> (14 - 2 * (x % 8))) & 16'h0003);
                expv = {2'((bgp_val >> (2 * p)) & 8'h03), (x == 0), (acc == 0)};
                if (act !== expv) begin
                    bad++;
                    if (first_i < 0) begin
                        first_i   = acc;
                        first_act = act;
                        first_exp = expv;
                    end
                end
                started = 1'b1;
                acc++;
            end
            hold_prev = (oPixelValid === 1'b1) && (iPixelReady !== 1'b1);
            prev_out  = act;
            @(posedge iClock); #1;
            cyc++;
        end
        iFrameBufferWe = 1'b0;
        n_cmp++;
        if (acc !== stop_idx) begin
            n_bad++;
            $display("FAIL %s_count: accepted %0d pixels, expected %0d (cycle budget ran out)", name, acc, stop_idx);
        end
        n_cmp++;
        if (bad !== 0) begin
            n_bad++;
            $display("FAIL %s_pixels: %0d wrong, first at %0d got {pix,ls,fs}=%h expected %h",
                     name, bad, first_i, first_act, first_exp);
        end
        if (!rand_ready) begin
            n_cmp++;
            if (bubbles !== 0) begin
                n_bad++;
                $display("FAIL %s_bubbles: got %0d invalid cycles mid-frame, expected 0", name, bubbles);
            end
        end else begin
            n_cmp++;
            if (hold_bad !== 0) begin
                n_bad++;
                $display("FAIL %s_hold: got %0d output changes while stalled, expected 0", name, hold_bad);
            end
        end
    endtask

    task automatic check_bank(input string name, input logic front_exp, input logic pend_exp);
        n_cmp++;
        if (oFrontBank !== front_exp) begin
            n_bad++;
            $display("FAIL %s_front: got %b expected %b", name, oFrontBank, front_exp);
        end
        n_cmp++;
        if (oSwapPending !== pend_exp) begin
            n_bad++;
            $display("FAIL %s_pending: got %b expected %b", name, oSwapPending, pend_exp);
        end
    endtask

    task automatic idle_valid_count(input string name, input int cycles);
        int seen = 0;
        iPixelReady = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            if (oPixelValid !== 1'b0) seen++;
            @(posedge iClock); #1;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL %s_idle: got %0d valid cycles, expected 0", name, seen);
        end
    endtask

    task automatic test_reset;
        n_cmp++;
        if ({oPixelValid, oPixel, oLineStart, oFrameStart} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b expected 00000", {oPixelValid, oPixel, oLineStart, oFrameStart});
        end
        check_bank("reset", 1'b0, 1'b0);
        iReset = 1'b1;
        idle_valid_count("no_writes", 1000);
        check_bank("no_writes", 1'b0, 1'b0);
    endtask

    task automatic test_first_frame;
        iBGP = 8'hE4;
        for (int k = 0; k < FRAME_WORDS; k++) write_word(16'(k), 16'h1B1B);
        check_bank("completion", 1'b0, 1'b1);
        scan_frame("frame0_e4", 16'h1B1B, 8'hE4, 1'b0, 0, 16'h0000, 0, FRAME_PIX);
        check_bank("after_frame0", 1'b1, 1'b0);
    endtask

    task automatic test_palette_rescan;
        iBGP = 8'h1B;
        scan_frame("rescan_1b", 16'h1B1B, 8'h1B, 1'b0, 0, 16'h0000, 0, FRAME_PIX);
        check_bank("after_rescan", 1'b1, 1'b0);
    endtask

    task automatic test_random_ready;
        scan_frame("random_ready", 16'h1B1B, 8'h1B, 1'b1, 0, 16'h0000, 0, FRAME_PIX);
        check_bank("after_random", 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back;
        iBGP = 8'hE4;
        scan_frame("frameA_head", 16'h1B1B, 8'hE4, 1'b0, FRAME_WORDS, 16'hFFFF, 0, 1000);
        check_bank("frameB_written", 1'b1, 1'b1);
        scan_frame("frameA_tail", 16'h1B1B, 8'hE4, 1'b0, 0, 16'h0000, 1000, FRAME_PIX);
        check_bank("swap_at_end", 1'b0, 1'b0);
        iBGP = 8'h40;
        scan_frame("frameB", 16'hFFFF, 8'h40, 1'b0, 0, 16'h0000, 0, FRAME_PIX);
        check_bank("after_frameB", 1'b0, 1'b0);
        scan_frame("frameB_rescan", 16'hFFFF, 8'h40, 1'b0, 0, 16'h0000, 0, FRAME_PIX);
        check_bank("after_frameB_rescan", 1'b0, 1'b0);
    endtask

    task automatic test_reset_midframe;
        scan_frame("abort_head", 16'hFFFF, 8'h40, 1'b0, 1, 16'h1B1B, 0, 1000);
        check_bank("pending_before_reset", 1'b0, 1'b1);
        iReset = 1'b0;
        #1;
        n_cmp++;
        if (oPixelValid !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_valid: got %b expected 0", oPixelValid);
        end
        check_bank("in_reset", 1'b0, 1'b0);
        @(posedge iClock); @(posedge iClock); #1;
        iReset = 1'b1;
        idle_valid_count("post_reset", 50);
        check_bank("post_reset", 1'b0, 1'b0);
        iBGP = 8'hE4;
        write_word(16'd255, 16'h1B1B);
        scan_frame("restart", 16'h1B1B, 8'hE4, 1'b0, 0, 16'h0000, 0, FRAME_PIX);
        check_bank("after_restart", 1'b1, 1'b0);
    endtask

    initial begin
        iClock           = 1'b0;
        iReset           = 1'b0;
        iFrameBufferWe   = 1'b0;
        iFrameBufferAddr = 16'h0000;
        iFrameBufferData = 16'h0000;
        iBGP             = 8'hE4;
        iPixelReady      = 1'b0;
        repeat (3) @(posedge iClock);
        #1;
        test_reset;
        test_first_frame;
        test_palette_rescan;
        test_random_ready;
        test_back_to_back;
        test_reset_midframe;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
